// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: the sequencer stage
// encoding, opcode constants and the datapath word width.
package cpu_pkg;

    localparam int STAGE_W = 3;
    localparam int WORD_W  = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [STAGE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_READ      = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } stage_t;

endpackage

// File: rtl/key_edge_sync.sv
// KEY0 conditioning: two-flop synchronizer followed by an edge register.
// press is a one-cycle pulse on every 1-to-0 transition of the synchronized
// button level. No debounce; all flops preset to 1 (button released).
module key_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain plus the previous-value register for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign press = prev_r & ~sync2_r;

endmodule

// File: rtl/stage_controller.sv
// Multi-cycle sequencer: IDLE -> FETCH -> DECODE -> READ -> EXECUTE ->
// WRITEBACK, with free-run or KEY0 single-step, and a sticky HALT state.
// Strobes are registered copies of the next-state decode, so they line up
// exactly with the stage they belong to.
// Optional macro STAGE_CTRL_BREAKPOINT_EN: stop free-run when pc == bp_addr.
module stage_controller
    import cpu_pkg::*;
#(
    parameter logic [3:0] HALT_OP = OP_HALT,
    parameter logic [3:0] NOP_OP  = OP_NOP,
    parameter int         CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key0_n,
    input  logic              run_mode,
    input  logic [3:0]        codop,
    input  logic [15:0]       pc,
    input  logic [15:0]       bp_addr,
    output logic              fetch_en,
    output logic              pc_inc,
    output logic              decode_en,
    output logic              in_read,
    output logic              alu_en,
    output logic              in_write,
    output logic [2:0]        stage,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    stage_t           state_r;
    stage_t           next_s;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] count_r;
    logic             press_s;
    logic             bp_hit_s;

    key_edge_sync u_key (
        .clock (clock),
        .reset (reset),
        .key_n (key0_n),
        .press (press_s)
    );

`ifdef STAGE_CTRL_BREAKPOINT_EN
    assign bp_hit_s = (pc == bp_addr);
`else
    // Breakpoint inputs are intentionally left dangling in this build.
    logic unused_bp_s;
    assign unused_bp_s = ^{pc, bp_addr};
    assign bp_hit_s    = 1'b0;
`endif

    // Next-state logic; a press always starts one instruction, run_mode only
    // when no breakpoint matches. run_mode matters only in IDLE/WRITEBACK.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s || (run_mode && !bp_hit_s)) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_FETCH:   next_s = ST_DECODE;
            ST_DECODE: begin
                if (codop == HALT_OP) begin
                    next_s = ST_HALT;
                end else begin
                    next_s = ST_READ;
                end
            end
            ST_READ:    next_s = ST_EXECUTE;
            ST_EXECUTE: next_s = ST_WRITEBACK;
            ST_WRITEBACK: begin
                if (run_mode && !bp_hit_s) begin
                    next_s = ST_FETCH;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_HALT:    next_s = ST_HALT;
            default:    next_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode latch, captured at the end of DECODE for the writeback decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r <= 4'h0;
        end else if (state_r == ST_DECODE) begin
            op_r <= codop;
        end else begin
            op_r <= op_r;
        end
    end

    // Retired-instruction counter, bumped as WRITEBACK completes (wraps).
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WRITEBACK) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Registered strobes decoded from the state about to be entered; op_r is
    // already valid whenever WRITEBACK is next (current state is EXECUTE).
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_en  <= 1'b0;
            pc_inc    <= 1'b0;
            decode_en <= 1'b0;
            in_read   <= 1'b0;
            alu_en    <= 1'b0;
            in_write  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            fetch_en  <= (next_s == ST_FETCH);
            pc_inc    <= (next_s == ST_FETCH);
            decode_en <= (next_s == ST_DECODE);
            in_read   <= (next_s == ST_READ);
            alu_en    <= (next_s == ST_EXECUTE);
            in_write  <= (next_s == ST_WRITEBACK) && (op_r != NOP_OP);
            halted    <= (next_s == ST_HALT);
        end
    end

    assign stage       = state_r;
    assign instr_count = count_r;

endmodule
